// File: rtl/tsp_pkg.sv
// Constants, state encoding and helpers shared by the TSP solver and the route player.
package tsp_pkg;

    localparam int N_CITIES = 6;
    localparam int CITY_W   = 3;
    localparam int ROUTE_W  = N_CITIES * CITY_W;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PLAY,
        GAP,
        ERROR
    } state_t;

    // Out-of-range city codes map to an all-zero mask.
    function automatic logic [N_CITIES-1:0] onehot_city(input logic [CITY_W-1:0] city);
        logic [N_CITIES-1:0] m;
        m = '0;
        for (int c = 0; c < N_CITIES; c++) begin
            if (city == CITY_W'(c)) begin
                m[c] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tsp_route_checker.sv
// Purpose: decides whether a packed tour is a permutation of cities 0..N_CITIES-1.
// Latency: purely combinational. Backpressure: none, no handshake.
import tsp_pkg::*;

module tsp_route_checker (
    input  logic [ROUTE_W-1:0]  route,
    output logic                valid,
    output logic [N_CITIES-1:0] seen
);

    logic in_range;
    logic distinct;

    always_comb begin
        seen     = '0;
        in_range = 1'b1;
        distinct = 1'b1;
        for (int i = 0; i < N_CITIES; i++) begin
            if (route[i*CITY_W +: CITY_W] >= CITY_W'(N_CITIES)) begin
                in_range = 1'b0;
            end
            seen = seen | onehot_city(route[i*CITY_W +: CITY_W]);
            for (int j = 0; j < i; j++) begin
                if (route[i*CITY_W +: CITY_W] == route[j*CITY_W +: CITY_W]) begin
                    distinct = 1'b0;
                end
            end
        end
        valid = in_range && distinct;
    end

endmodule

// File: rtl/tsp_route_player.sv
// Purpose: accepts a 6-city tour, validates it, then replays it on the LEDs in a loop (blinks all on error).
// Latency: transfer at edge T, one CHECK cycle, first city LED visible after edge T+2.
// Backpressure: route_ready only in IDLE/ERROR and forced low while stop is high.
import tsp_pkg::*;

module tsp_route_player #(
    parameter int DWELL_CYCLES   = 13_500_000,
    parameter int GAP_CYCLES     = 2_700_000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                route_valid,
    output logic                route_ready,
    input  logic [ROUTE_W-1:0]  route_data,
    input  logic                stop,
    output logic [N_CITIES-1:0] led,
    output logic                busy,
    output logic                err,
    output logic                lap_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [N_CITIES-1:0] LED_OFF = {N_CITIES{LED_ACTIVE_LOW}};
    localparam logic [N_CITIES-1:0] LED_ON  = ~LED_OFF;

    state_t               state, state_n;
    logic [CITY_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 blink_on, blink_on_n;
    logic                 lap_n;
    logic                 adv;
    logic                 take;
    logic                 ready_q;
    logic [ROUTE_W-1:0]   route_q;
    logic [N_CITIES-1:0]  led_n;
    logic [N_CITIES-1:0]  led_city;
    logic                 chk_valid;
    logic [N_CITIES-1:0]  chk_seen;
    logic                 route_ok;

    tsp_route_checker u_checker (
        .route (route_q),
        .valid (chk_valid),
        .seen  (chk_seen)
    );

    assign route_ok    = chk_valid && (&chk_seen);
    assign route_ready = ready_q && !stop;
    assign take        = route_valid && route_ready;
    assign led_city    = onehot_city(route_q[idx*CITY_W +: CITY_W]) ^ LED_OFF;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        blink_on_n = blink_on;
        lap_n      = 1'b0;
        adv        = 1'b0;
        if (stop) begin
            state_n    = IDLE;
            idx_n      = '0;
            cnt_n      = '0;
            blink_on_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state_n = CHECK;
                        cnt_n   = '0;
                    end
                end
                CHECK: begin
                    cnt_n = '0;
                    idx_n = '0;
                    if (route_ok) begin
                        state_n = PLAY;
                    end else begin
                        state_n    = ERROR;
                        blink_on_n = 1'b1;
                    end
                end
                PLAY: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_n = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_n   = '0;
                        state_n = PLAY;
                        adv     = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ERROR: begin
                    if (take) begin
                        state_n    = CHECK;
                        cnt_n      = '0;
                        blink_on_n = 1'b0;
                    end else if (cnt == DWELL_LAST) begin
                        cnt_n      = '0;
                        blink_on_n = !blink_on;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
            if (adv) begin
                if (idx == CITY_W'(N_CITIES - 1)) begin
                    idx_n = '0;
                    lap_n = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end

        // The city image lags the state by one cycle so each city shows for a full dwell.
        led_n = LED_OFF;
        if (state_n == ERROR) begin
            led_n = blink_on_n ? LED_ON : LED_OFF;
        end else if (state_n != IDLE && state == PLAY) begin
            led_n = led_city;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx      <= '0;
            cnt      <= '0;
            blink_on <= 1'b0;
            route_q  <= '0;
            ready_q  <= 1'b1;
            led      <= LED_OFF;
            busy     <= 1'b0;
            err      <= 1'b0;
            lap_done <= 1'b0;
        end else begin
            idx      <= idx_n;
            cnt      <= cnt_n;
            blink_on <= blink_on_n;
            if (take) begin
                route_q <= route_data;
            end
            ready_q  <= (state_n == IDLE) || (state_n == ERROR);
            led      <= led_n;
            busy     <= (state_n == CHECK) || (state_n == PLAY) || (state_n == GAP);
            err      <= (state_n == ERROR);
            lap_done <= lap_n;
        end
    end

endmodule

// File: tb/tb_tsp_route_player.sv
// Directed bench for tsp_route_player (DWELL=4, GAP=2, active-low LEDs) plus a no-gap instance.
module tb_tsp_route_player;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        route_valid;
    logic        route_valid_ng;
    logic [17:0] route_data;
    logic        stop;

    logic        route_ready, busy, err, lap_done;
    logic [5:0]  led;
    logic        route_ready_ng, busy_ng, err_ng, lap_done_ng;
    logic [5:0]  led_ng;

    logic [17:0] ref_route;
    logic        ref_valid;
    logic [5:0]  ref_seen;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    tsp_route_player #(.DWELL_CYCLES(4), .GAP_CYCLES(2), .LED_ACTIVE_LOW(1'b1)) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .route_valid (route_valid),
        .route_ready (route_ready),
        .route_data  (route_data),
        .stop        (stop),
        .led         (led),
        .busy        (busy),
        .err         (err),
        .lap_done    (lap_done)
    );

    tsp_route_player #(.DWELL_CYCLES(4), .GAP_CYCLES(0), .LED_ACTIVE_LOW(1'b1)) u_dut_ng (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .route_valid (route_valid_ng),
        .route_ready (route_ready_ng),
        .route_data  (route_data),
        .stop        (stop),
        .led         (led_ng),
        .busy        (busy_ng),
        .err         (err_ng),
        .lap_done    (lap_done_ng)
    );

    tsp_route_checker u_ref (
        .route (ref_route),
        .valid (ref_valid),
        .seen  (ref_seen)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Offer a tour for exactly one edge; ready is expected high at that edge.
    task automatic send_route(input logic [17:0] d, input bit to_ng);
        route_data = d;
        if (to_ng) route_valid_ng = 1'b1;
        else       route_valid    = 1'b1;
        tick();
        route_valid    = 1'b0;
        route_valid_ng = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 6'b111111 || route_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || lap_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: led=%b rdy=%b busy=%b err=%b lap=%b required led=111111 rdy=1 busy=0 err=0 lap=0",
                     led, route_ready, busy, err, lap_done);
        end
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        tick();
        checks++;
        if (led !== 6'b111111 || route_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: led=%b rdy=%b busy=%b err=%b required 111111 1 0 0", led, route_ready, busy, err);
        end
        checks++;
        if (led_ng !== 6'b111111 || route_ready_ng !== 1'b1 || err_ng !== 1'b0) begin
            errors++;
            $display("FAIL reset_ng: led=%b rdy=%b err=%b required 111111 1 0", led_ng, route_ready_ng, err_ng);
        end
    endtask

    task automatic test_checker_model();
        logic [17:0] vec   [3];
        logic        exp_v [3];
        logic [5:0]  exp_s [3];
        vec[0] = 18'o543210; exp_v[0] = 1'b1; exp_s[0] = 6'b111111;
        vec[1] = 18'o543110; exp_v[1] = 1'b0; exp_s[1] = 6'b111011;
        vec[2] = 18'o543216; exp_v[2] = 1'b0; exp_s[2] = 6'b111110;
        for (int i = 0; i < 3; i++) begin
            ref_route = vec[i];
            #1;
            checks++;
            if (ref_valid !== exp_v[i] || ref_seen !== exp_s[i]) begin
                errors++;
                $display("FAIL checker_vec%0d: valid=%b seen=%b required valid=%b seen=%b",
                         i, ref_valid, ref_seen, exp_v[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_valid_playback();
        logic [5:0] exp_led;
        logic [5:0] one;
        int c, pos;
        send_route(18'o543210, 1'b0);
        checks++;
        if (route_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL play_accept: rdy=%b busy=%b required rdy=0 busy=1", route_ready, busy);
        end
        tick();
        checks++;
        if (led !== 6'b111111) begin
            errors++;
            $display("FAIL play_check_cycle: led=%b required 111111", led);
        end
        for (int k = 0; k < 48; k++) begin
            tick();
            c   = (k / 6) % 6;
            pos = k % 6;
            one = 6'b000001 << c;
            exp_led = (pos < 4) ? ~one : 6'b111111;
            checks++;
            if (led !== exp_led || lap_done !== (k == 35)) begin
                errors++;
                $display("FAIL play_k%0d: led=%b lap=%b required led=%b lap=%b", k, led, lap_done, exp_led, (k == 35));
            end
        end
        go_idle();
    endtask

    task automatic test_duplicate_city();
        logic [5:0] exp_led;
        send_route(18'o543110, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_led = (((k / 4) % 2) == 0) ? 6'b000000 : 6'b111111;
            checks++;
            if (led !== exp_led || err !== 1'b1 || route_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dup_k%0d: led=%b err=%b rdy=%b busy=%b required led=%b err=1 rdy=1 busy=0",
                         k, led, err, route_ready, busy, exp_led);
            end
        end
    endtask

    task automatic test_out_of_range();
        send_route(18'o543216, 1'b0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL oor_leave_error: err=%b required 0", err);
        end
        tick();
        checks++;
        if (err !== 1'b1 || led !== 6'b000000) begin
            errors++;
            $display("FAIL oor_error: err=%b led=%b required err=1 led=000000", err, led);
        end
        send_route(18'o012345, 1'b0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL oor_recover: err=%b busy=%b required err=0 busy=1", err, busy);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (led !== 6'b011111 || err !== 1'b0) begin
                errors++;
                $display("FAIL oor_first_city_k%0d: led=%b err=%b required led=011111 err=0", k, led, err);
            end
        end
        go_idle();
    endtask

    task automatic test_stop_mid_play();
        send_route(18'o543210, 1'b0);
        repeat (20) tick();
        checks++;
        if (led !== 6'b110111) begin
            errors++;
            $display("FAIL stop_city3_lit: led=%b required 110111", led);
        end
        stop        = 1'b1;
        route_valid = 1'b1;
        route_data  = 18'o012345;
        #1;
        checks++;
        if (route_ready !== 1'b0) begin
            errors++;
            $display("FAIL stop_ready_gated: rdy=%b required 0", route_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (led !== 6'b111111 || busy !== 1'b0 || err !== 1'b0 || route_ready !== 1'b0) begin
                errors++;
                $display("FAIL stop_hold_k%0d: led=%b busy=%b err=%b rdy=%b required 111111 0 0 0",
                         k, led, busy, err, route_ready);
            end
        end
        route_valid = 1'b0;
        stop        = 1'b0;
        tick();
        checks++;
        if (route_ready !== 1'b1 || busy !== 1'b0 || led !== 6'b111111) begin
            errors++;
            $display("FAIL stop_release: rdy=%b busy=%b led=%b required 1 0 111111", route_ready, busy, led);
        end
    endtask

    task automatic test_no_gap();
        logic [5:0] one;
        send_route(18'o543210, 1'b1);
        tick();
        checks++;
        if (led_ng !== 6'b111111 || busy_ng !== 1'b1) begin
            errors++;
            $display("FAIL nogap_check_cycle: led=%b busy=%b required 111111 1", led_ng, busy_ng);
        end
        for (int k = 0; k < 28; k++) begin
            tick();
            one = 6'b000001 << ((k / 4) % 6);
            checks++;
            if (led_ng !== ~one || lap_done_ng !== (k == 23) || err_ng !== 1'b0) begin
                errors++;
                $display("FAIL nogap_k%0d: led=%b lap=%b err=%b required led=%b lap=%b err=0",
                         k, led_ng, lap_done_ng, err_ng, ~one, (k == 23));
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_play();
        send_route(18'o543210, 1'b0);
        repeat (3) tick();
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 6'b111111 || busy !== 1'b0 || route_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: led=%b busy=%b rdy=%b required 111111 0 1", led, busy, route_ready);
        end
        tick();
        sys_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (led !== 6'b111111 || busy !== 1'b0 || lap_done !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_k%0d: led=%b busy=%b lap=%b required 111111 0 0", k, led, busy, lap_done);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        route_valid    = 1'b0;
        route_valid_ng = 1'b0;
        route_data     = '0;
        stop           = 1'b0;
        ref_route      = '0;
        test_reset();
        test_checker_model();
        test_valid_playback();
        test_duplicate_city();
        test_out_of_range();
        test_stop_mid_play();
        test_no_gap();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
